cache_controller: RTL and testbench

- 2-way set-associative, write-through, no-write-allocate read cache between the MEM stage and sram_controller.
- Read hits return data combinationally with no stall.
- Misses and all writes are forwarded to sram_controller; `ready` freezes the pipeline until that transfer completes.
- Addresses pass through unmodified; sram_controller applies the 1024 data-base offset.

---
 rtl/cache_controller_pkg.sv | 17 +
 rtl/cache_controller_if.sv | 15 +
 rtl/cache_controller_way_array.sv | 43 ++++
 rtl/cache_controller.sv | 154 +++++++++++++++
 tb/tb_cache_controller.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_controller_pkg.sv
// Shared definitions for the MEM-stage read cache: FSM state encoding,
// the data-region base applied downstream by sram_controller, default geometry.
package cache_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Applied by sram_controller, not here; addresses pass through untouched.
  localparam logic [31:0] DATA_BASE = 32'd1024;

  localparam int DEFAULT_SETS = 64;

endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage <-> cache request bus. master = pipeline MEM stage, slave = cache.
interface cache_controller_if;
  import cache_controller_pkg::*;

  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output wr_en, rd_en, address, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, address, wdata, output rdata, ready);

endinterface

// File: rtl/cache_controller_way_array.sv
// One way of the cache: valid/tag/data per set with a single write port and
// combinational hit/data lookup. Only the valid bits are reset.
module cache_way_array
  import cache_controller_pkg::*;
#(
  parameter int SETS  = DEFAULT_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 32 - 2 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic             wr,
  input  logic [31:0]      wdata,
  output logic             valid,
  output logic             hit,
  output logic [31:0]      rdata
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS];

  // Valid bits: cleared by reset, set by any write (fill or write hit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (wr) valid_q[idx] <= 1'b1;
  end

  // Tag/data storage; a write hit rewrites the same tag so one port serves both cases.
  always_ff @(posedge clk) begin
    if (wr) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= wdata;
    end
  end

  assign valid = valid_q[idx];
  assign hit   = valid && (tag_mem[idx] == tag);
  assign rdata = data_mem[idx];

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache between
// the MEM stage and sram_controller. Optional macro CACHE_STATS_EN adds
// saturating hit_count/miss_count outputs.
//
// state | meaning
// IDLE  | accept requests; read hits served combinationally
// MISS  | read request held to sram_controller until it completes
// WRITE | write-through request held to sram_controller until it completes
// DONE  | release the pipeline for one cycle; held MEM request is ignored
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int SETS = DEFAULT_SETS
) (
  input  logic                clk,
  input  logic                rst,
  cache_controller_if.slave   bus,
  output logic                sram_wr_en,
  output logic                sram_rd_en,
  output logic [31:0]         sram_address,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata,
  input  logic                sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - IDX_W;

  state_t           state, state_nxt;
  logic             seen_busy, rd_pending;
  logic [31:0]      fill_reg;
  logic [SETS-1:0]  lru;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       hit, valid, way_wr;
  logic [31:0]      data0, data1, way_wdata;
  logic             victim, done, busy_clr, fill_we, lru_we, lru_new;

  assign idx          = bus.address[2+IDX_W-1:2];
  assign tag          = bus.address[31:2+IDX_W];
  assign sram_address = bus.address;
  assign sram_wdata   = bus.wdata;
  assign victim       = !valid[0] ? 1'b0 : (!valid[1] ? 1'b1 : lru[idx]);
  // Only a completion after the controller has actually gone busy counts.
  assign done         = sram_ready && seen_busy;

  cache_way_array #(.SETS(SETS)) u_way0 (
    .clk(clk), .rst(rst), .idx(idx), .tag(tag), .wr(way_wr[0]), .wdata(way_wdata),
    .valid(valid[0]), .hit(hit[0]), .rdata(data0)
  );

  cache_way_array #(.SETS(SETS)) u_way1 (
    .clk(clk), .rst(rst), .idx(idx), .tag(tag), .wr(way_wr[1]), .wdata(way_wdata),
    .valid(valid[1]), .hit(hit[1]), .rdata(data1)
  );

  // Next state, bus outputs, and array/LRU write strobes.
  always_comb begin
    state_nxt  = state;
    bus.ready  = 1'b1;
    bus.rdata  = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    way_wr     = '0;
    way_wdata  = bus.wdata;
    lru_we     = 1'b0;
    lru_new    = 1'b0;
    busy_clr   = 1'b0;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_en) begin
          bus.ready = 1'b0;
          state_nxt = WRITE;
          busy_clr  = 1'b1;
          way_wr    = hit;
          lru_we    = |hit;
          lru_new   = hit[0];
        end else if (bus.rd_en) begin
          if (|hit) begin
            bus.rdata = hit[1] ? data1 : data0;
            lru_we    = 1'b1;
            lru_new   = hit[0];
          end else begin
            bus.ready = 1'b0;
            state_nxt = MISS;
            busy_clr  = 1'b1;
          end
        end
      end
      MISS: begin
        sram_rd_en = 1'b1;
        bus.ready  = 1'b0;
        if (done) begin
          fill_we        = 1'b1;
          way_wr[victim] = 1'b1;
          way_wdata      = sram_rdata;
          lru_we         = 1'b1;
          lru_new        = ~victim;
          state_nxt      = DONE;
        end
      end
      WRITE: begin
        sram_wr_en = 1'b1;
        bus.ready  = 1'b0;
        if (done) state_nxt = DONE;
      end
      DONE: begin
        bus.rdata = rd_pending ? fill_reg : 32'd0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus busy tracking, fill capture and LRU bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      seen_busy  <= 1'b0;
      rd_pending <= 1'b0;
      fill_reg   <= '0;
      lru        <= '0;
    end else begin
      state <= state_nxt;
      if (busy_clr) seen_busy <= 1'b0;
      else if ((state == MISS || state == WRITE) && !sram_ready) seen_busy <= 1'b1;
      if (busy_clr) rd_pending <= (state_nxt == MISS);
      if (fill_we) fill_reg <= sram_rdata;
      if (lru_we) lru[idx] <= lru_new;
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating read hit/miss counters; writes are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && !bus.wr_en && bus.rd_en && (|hit) && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_nxt == MISS && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: behavioural sram_controller
// (6-cycle busy), directed vector table, reset-mid-miss sequence, and random
// traffic checked against a set/way/LRU reference model.
module tb_cache_controller;
  localparam int SETS  = 64;
  localparam int IDX_W = 6;
  localparam int TAG_W = 32 - 2 - IDX_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_wr_en, sram_rd_en, sram_ready;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cache_controller_if bus ();

  cache_controller dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // ---------------- behavioural sram_controller ----------------
  logic [31:0] smem [logic [31:0]];
  int          s_cnt;
  bit          s_busy, s_done, s_wr;
  logic [31:0] s_addr, s_wd, s_rdata;

  assign sram_rdata = s_rdata;
  always_comb sram_ready = s_busy ? 1'b0 : (s_done ? 1'b1 : !(sram_rd_en || sram_wr_en));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_busy <= 0; s_done <= 0; s_cnt <= 0; s_rdata <= '0;
    end else if (s_busy) begin
      if (s_cnt == 1) begin
        s_busy <= 0;
        s_done <= 1;
        if (s_wr) smem[s_addr] = s_wd;
        else s_rdata <= smem.exists(s_addr) ? smem[s_addr] : init_val(s_addr);
      end
      s_cnt <= s_cnt - 1;
    end else if (s_done) begin
      if (!(sram_rd_en || sram_wr_en)) s_done <= 0;
    end else if (sram_rd_en || sram_wr_en) begin
      s_busy <= 1; s_cnt <= 6;
      s_wr <= sram_wr_en; s_addr <= sram_address; s_wd <= sram_wdata;
    end
  end

  // ---------------- reference model ----------------
  bit               m_valid [SETS][2];
  logic [TAG_W-1:0] m_tag   [SETS][2];
  logic [31:0]      m_data  [SETS][2];
  int               m_lru   [SETS];
  logic [31:0]      gmem    [logic [31:0]];
  int               ex_hits, ex_misses;

  function automatic int set_of(input logic [31:0] a);
    return int'((a / 4) % SETS);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
    return TAG_W'(a / (4 * SETS));
  endfunction

  function automatic int find_way(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_valid[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) return w;
    return -1;
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s][0] = 0; m_valid[s][1] = 0; m_lru[s] = 0;
    end
    ex_hits = 0; ex_misses = 0;
  endtask

  task automatic model_update(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int s, w, v;
    s = set_of(a);
    w = find_way(a);
    if (wr) begin
      gmem[a] = d;
      if (w >= 0) begin m_data[s][w] = d; m_lru[s] = 1 - w; end
    end else if (w >= 0) begin
      m_lru[s] = 1 - w; ex_hits++;
    end else begin
      ex_misses++;
      v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : m_lru[s]);
      m_valid[s][v] = 1; m_tag[s][v] = tag_of(a); m_data[s][v] = golden(a);
      m_lru[s] = 1 - v;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input bit exp_hit, input logic [31:0] exp_rd, input string nm);
    bit saw_req;
    int n;
    @(negedge clk);
    bus.wr_en = wr; bus.rd_en = !wr; bus.address = a; bus.wdata = d;
    #1;
    if (!wr && exp_hit) begin
      chk({nm, " hit ready"}, bus.ready, 1);
      chk({nm, " hit rdata"}, bus.rdata, exp_rd);
      chk({nm, " hit no sram req"}, sram_rd_en, 0);
      @(negedge clk);
    end else begin
      chk({nm, " stall"}, bus.ready, 0);
      saw_req = 0; n = 0;
      while (!bus.ready && n < 60) begin
        @(negedge clk); n++;
        if ((sram_rd_en || sram_wr_en) && !saw_req) begin
          saw_req = 1;
          chk({nm, " sram_wr_en"}, sram_wr_en, wr);
          chk({nm, " sram_rd_en"}, sram_rd_en, !wr);
          chk({nm, " sram_address"}, sram_address, a);
          if (wr) chk({nm, " sram_wdata"}, sram_wdata, d);
        end
      end
      chk({nm, " done within bound"}, bus.ready, 1);
      chk({nm, " sram request seen"}, saw_req, 1);
      chk({nm, " done rdata"}, bus.rdata, exp_rd);
    end
    bus.wr_en = 0; bus.rd_en = 0;
    model_update(wr, a, d);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1; bus.wr_en = 0; bus.rd_en = 0;
    #1;
    chk("reset ready", bus.ready, 1);
    chk("reset sram_rd_en", sram_rd_en, 0);
    chk("reset sram_wr_en", sram_wr_en, 0);
    chk("reset rdata", bus.rdata, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  typedef struct {
    bit          pre_rst;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h;
    int          w;
    logic [31:0] a, d, e;

    bus.wr_en = 0; bus.rd_en = 0; bus.address = '0; bus.wdata = '0;
    model_reset();

    tbl[0]  = '{0, 1, 32'h400, 32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{0, 0, 32'h400, 32'h0,        0, 32'hDEADBEEF};
    tbl[2]  = '{0, 0, 32'h400, 32'h0,        1, 32'hDEADBEEF};
    tbl[3]  = '{0, 1, 32'h400, 32'h12345678, 1, 32'h0};
    tbl[4]  = '{0, 0, 32'h400, 32'h0,        1, 32'h12345678};
    tbl[5]  = '{1, 0, 32'h400, 32'h0,        0, 32'h12345678};
    tbl[6]  = '{0, 0, 32'h500, 32'h0,        0, 32'hA5A50500};
    tbl[7]  = '{0, 0, 32'h400, 32'h0,        1, 32'h12345678};
    tbl[8]  = '{0, 0, 32'h600, 32'h0,        0, 32'hA5A50600};
    tbl[9]  = '{0, 0, 32'h400, 32'h0,        1, 32'h12345678};
    tbl[10] = '{0, 0, 32'h600, 32'h0,        1, 32'hA5A50600};
    tbl[11] = '{0, 0, 32'h500, 32'h0,        0, 32'hA5A50500};

    #2;
    chk("initial reset ready", bus.ready, 1);
    chk("initial reset sram_rd_en", sram_rd_en, 0);
    chk("initial reset sram_wr_en", sram_wr_en, 0);
    chk("initial reset rdata", bus.rdata, 0);
`ifdef CACHE_STATS_EN
    chk("initial reset hit_count", hit_count, 0);
    chk("initial reset miss_count", miss_count, 0);
`endif
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].pre_rst) pulse_reset();
      do_access(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].hit, tbl[i].rd,
                $sformatf("vec%0d", i));
    end
`ifdef CACHE_STATS_EN
    chk("lru scenario hit_count", hit_count, 3);
    chk("lru scenario miss_count", miss_count, 4);
`endif

    // Reset in the middle of a read miss.
    w = find_way(32'h400);
    do_access(0, 32'h400, 0, w >= 0, golden(32'h400), "refill 400");
    do_access(0, 32'h400, 0, 1, golden(32'h400), "hit 400");
    @(negedge clk);
    bus.rd_en = 1; bus.address = 32'h700;
    repeat (3) @(negedge clk);
    chk("mid-miss sram_rd_en", sram_rd_en, 1);
    rst = 1; bus.rd_en = 0;
    #1;
    chk("rst mid-miss sram_rd_en", sram_rd_en, 0);
    chk("rst mid-miss ready", bus.ready, 1);
    @(negedge clk);
    rst = 0;
    model_reset();
    do_access(0, 32'h400, 0, 0, golden(32'h400), "post-reset 400 misses");

    // Random traffic over a few conflicting sets.
    for (int i = 0; i < 300; i++) begin
      a = 32'h400 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 1)) << 2);
      d = $urandom;
      h = find_way(a) >= 0;
      if ($urandom_range(0, 9) < 3) begin
        do_access(1, a, d, h, 32'h0, $sformatf("rnd%0d wr", i));
      end else begin
        e = golden(a);
        do_access(0, a, 0, h, e, $sformatf("rnd%0d rd", i));
      end
    end
`ifdef CACHE_STATS_EN
    chk("random hit_count", hit_count, ex_hits);
    chk("random miss_count", miss_count, ex_misses);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
